// File: rtl/sr_latch.sv
// Clocked SR storage element with registered true/complement outputs.
// HOLD_ON_FORBIDDEN picks the S=R=1 policy: 0 forces both outputs low, 1 holds.
module sr_latch #(
  parameter bit HOLD_ON_FORBIDDEN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q1,
  output logic q2
);

  // Both outputs are plain registers so s/r never reach them combinationally;
  // the forbidden state is an explicit 0/0 that persists until a valid set or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b1;
    end else begin
      case ({s, r})
        2'b01: begin
          q1 <= 1'b0;
          q2 <= 1'b1;
        end
        2'b10: begin
          q1 <= 1'b1;
          q2 <= 1'b0;
        end
        2'b11: begin
          if (!HOLD_ON_FORBIDDEN) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
          end
        end
        default: begin
          q1 <= q1;
          q2 <= q2;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch.sv
// Self-checking bench for sr_latch: drives both forbidden-state policies from
// one stimulus stream and checks them against a rule-based model and literals.
module tb_sr_latch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s = 1'b0;
  logic r = 1'b0;
  logic q1_force, q2_force;
  logic q1_hold, q2_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch #(.HOLD_ON_FORBIDDEN(1'b0)) dut_force (
    .clk(clk), .rst(rst), .s(s), .r(r), .q1(q1_force), .q2(q2_force)
  );

  sr_latch #(.HOLD_ON_FORBIDDEN(1'b1)) dut_hold (
    .clk(clk), .rst(rst), .s(s), .r(r), .q1(q1_hold), .q2(q2_hold)
  );

  // Model state as {q1,q2}; undefined until the first reset edge has been seen.
  logic [1:0] model_force;
  logic [1:0] model_hold;
  bit model_valid = 1'b0;

  function automatic logic [1:0] next_pair(input logic [1:0] cur, input logic rst_i,
                                           input logic s_i, input logic r_i,
                                           input bit hold_policy);
    if (rst_i)
      return 2'b01;
    if (s_i != r_i)
      return {s_i, r_i};
    if (s_i && r_i && !hold_policy)
      return 2'b00;
    return cur;
  endfunction

  always @(posedge clk) begin
    model_force <= next_pair(model_force, rst, s, r, 1'b0);
    model_hold  <= next_pair(model_hold, rst, s, r, 1'b1);
    if (rst)
      model_valid <= 1'b1;
  end

  task automatic compareOne(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got q1q2=%b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge once reset has happened.
  always @(negedge clk) begin
    if (model_valid) begin
      compareOne("model_force", {q1_force, q2_force}, model_force);
      compareOne("model_hold", {q1_hold, q2_hold}, model_hold);
    end
  end

  task automatic applyStimulus(input logic rst_v, input logic s_v, input logic r_v);
    @(negedge clk);
    rst = rst_v;
    s   = s_v;
    r   = r_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] exp_force, input logic [1:0] exp_hold);
    compareOne({name, "_force"}, {q1_force, q2_force}, exp_force);
    compareOne({name, "_hold"}, {q1_hold, q2_hold}, exp_hold);
  endtask

  initial begin
    // Reset priority over s=r=1, two edges
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_sr11", 2'b01, 2'b01);

    // Basic sequence
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_after_reset", 2'b01, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear", 2'b01, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("set", 2'b10, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_set", 2'b10, 2'b10);

    // Forbidden with force policy, then hold and recovery
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("forbidden_1", 2'b00, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("forbidden_hold", 2'b00, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("recover_set", 2'b10, 2'b10);

    // Three consecutive forbidden edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("forbidden_run%0d", i), 2'b00, 2'b10);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("recover_clear", 2'b01, 2'b01);

    // Idempotent set
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("set_again_1", 2'b10, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("set_again_2", 2'b10, 2'b10);

    // Mid-operation reset asserted between edges with (1,0) held
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_before_edge", 2'b10, 2'b10);
    @(posedge clk);
    #1;
    checkOutput("rst_after_edge", 2'b01, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_release", 2'b01, 2'b01);

    // s pulse entirely between edges must be ignored
    #1;
    s = 1'b1;
    #1;
    s = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("glitch_ignored", 2'b01, 2'b01);

    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
SR_LATCH -- requirements
Module: sr_latch

Interface
REQ-001 The block SHALL have exactly one parameter: HOLD_ON_FORBIDDEN, default 0, selecting the S=R=1 policy (0 = force q1=q2=0, 1 = hold the previous state).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port s, input, 1 bit: set request, sampled on the clk rising edge.
REQ-005 The block SHALL have port r, input, 1 bit: reset (clear) request, sampled on the clk rising edge.
REQ-006 The block SHALL have port q1, output, 1 bit: true state output Q.
REQ-007 The block SHALL have port q2, output, 1 bit: complement output Q-bar.
REQ-008 q1 and q2 SHALL each be driven directly by a register, with no combinational path from s or r to q1 or q2.

Function
REQ-009 The block SHALL act as a clocked SR storage element with 1-cycle latency: on each rising edge with rst=0, the (s,r) pair sampled at that edge SHALL determine q1/q2, visible immediately after that edge.
REQ-010 For s=0,r=0 (hold), q1 and q2 SHALL keep their current values.
REQ-011 For s=0,r=1 (clear), the block SHALL set q1=0 and q2=1.
REQ-012 For s=1,r=0 (set), the block SHALL set q1=1 and q2=0.
REQ-013 For s=1,r=1 with HOLD_ON_FORBIDDEN=0, the block SHALL set q1=0 and q2=0 (NOR-latch forbidden state).
REQ-014 For s=1,r=1 with HOLD_ON_FORBIDDEN=1, q1 and q2 SHALL keep their current values.
REQ-015 After a forbidden state (q1=q2=0), an s=0,r=0 cycle SHALL hold q1=q2=0; there SHALL be no race or random resolution.
REQ-016 From the forbidden state, the next valid set or clear SHALL restore complementary outputs per REQ-011/REQ-012.
REQ-017 Outside the forbidden state, q2 SHALL always equal the inverse of q1.
REQ-018 Changes on s or r between clock edges SHALL have no effect on the outputs.
REQ-019 Repeating a set or clear on consecutive cycles SHALL be idempotent.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL set q1=0 and q2=1, regardless of s and r.
REQ-021 rst SHALL take priority over all s/r combinations, including s=r=1.
REQ-022 Reset SHALL be synchronous: asserting rst between edges SHALL NOT change the outputs until the next rising edge.
REQ-023 Deasserting rst SHALL resume normal operation on the first rising edge where rst=0.
REQ-024 Before the first reset edge, the output values SHALL be undefined, and the bench SHALL NOT check them.

Verification
REQ-025 The bench SHALL check reset: rst=1 with s=1,r=1 for 2 edges -> q1=0,q2=1.
REQ-026 The bench SHALL check the full sequence after reset, 10 time units per step, one edge each: (0,0) -> q1=0,q2=1; (0,1) -> q1=0,q2=1; (1,0) -> q1=1,q2=0; (0,0) -> q1=1,q2=0 (hold).
REQ-027 The bench SHALL check the forbidden state with HOLD_ON_FORBIDDEN=0: from q1=1, apply (1,1) -> q1=0,q2=0; then (0,0) -> q1=0,q2=0; then (1,0) -> q1=1,q2=0.
REQ-028 The bench SHALL check the forbidden state with HOLD_ON_FORBIDDEN=1: from q1=1,q2=0, apply (1,1) for 3 edges -> q1=1,q2=0 throughout.
REQ-029 The bench SHALL check a mid-operation reset: with q1=1 after a set, assert rst between edges with (1,0) held -> no output change before the edge, then q1=0,q2=1 after the edge.
REQ-030 The bench SHALL check sampling: pulse s=1 high and low again between two edges -> q1/q2 unchanged at the next edge.
